// File: rtl/spi_accel_responder.sv
// SPI target that mimics an ADXL362-style accelerometer register interface.
// SPI pins are oversampled in the core clock domain (mode 0, MSB first).
// Host-side samples are loaded directly when idle, or deferred to CS release
// when a transaction is running, so a burst read never sees torn data.
module spi_accel_responder #(
    parameter logic [7:0] ID_AD   = 8'hAD,
    parameter logic [7:0] ID_MST  = 8'h1D,
    parameter logic [7:0] PART_ID = 8'hF2,
    parameter logic [7:0] REV_ID  = 8'h01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_sclk,
    input  logic        i_cs_n,
    input  logic        i_mosi,
    output logic        o_miso,
    input  logic        i_sample_valid,
    input  logic [11:0] i_x,
    input  logic [11:0] i_y,
    input  logic [11:0] i_z,
    output logic        o_busy
);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, IGNORE} state_t;

    state_t      state_q, state_d;
    logic        sclkMeta_q, sclkSync_q, sclkDly_q;
    logic        csMeta_q, csSync_q, csDly_q;
    logic        mosiMeta_q, mosiSync_q;
    logic [1:0]  settle_q;
    logic        armed_q;
    logic [2:0]  rxCnt_q;
    logic [7:0]  rxShift_q;
    logic        isRead_q;
    logic [5:0]  addr_q;
    logic [2:0]  txCnt_q;
    logic [6:0]  txShift_q;
    logic        misoBit_q;
    logic        miso_q;
    logic [11:0] x_q, y_q, z_q;
    logic [11:0] penX_q, penY_q, penZ_q;
    logic        pending_q;
    logic        dataReady_q;
    logic        readSample_q;
    logic [7:0]  store_q [32];

    logic        sclkRise, sclkFall, csFall, csRise;
    logic [7:0]  rxByte;
    logic        byteDone, commitWrite, softReset, txLoad, rdSample;
    logic [7:0]  rdData;

    assign sclkRise    = sclkSync_q & ~sclkDly_q;
    assign sclkFall    = ~sclkSync_q & sclkDly_q;
    assign csFall      = ~csSync_q & csDly_q;
    assign csRise      = csSync_q & ~csDly_q;
    assign rxByte      = {rxShift_q[6:0], mosiSync_q};
    assign byteDone    = sclkRise && (rxCnt_q == 3'd7);
    assign commitWrite = (state_q == DATA) && !isRead_q && byteDone && !csRise;
    assign softReset   = commitWrite && (addr_q == 6'h1F) && (rxByte == 8'h52);
    assign txLoad      = (state_q == DATA) && isRead_q && sclkFall && (txCnt_q == 3'd0);
    assign rdSample    = ((addr_q >= 6'h08) && (addr_q <= 6'h0A)) ||
                         ((addr_q >= 6'h0E) && (addr_q <= 6'h13));
    assign o_busy      = ~csDly_q;
    assign o_miso      = miso_q;

    // Two-flop synchronizers plus a third copy for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclkMeta_q <= 1'b0; sclkSync_q <= 1'b0; sclkDly_q <= 1'b0;
            csMeta_q   <= 1'b1; csSync_q   <= 1'b1; csDly_q   <= 1'b1;
            mosiMeta_q <= 1'b0; mosiSync_q <= 1'b0;
        end else begin
            sclkMeta_q <= i_sclk; sclkSync_q <= sclkMeta_q; sclkDly_q <= sclkSync_q;
            csMeta_q   <= i_cs_n; csSync_q   <= csMeta_q;   csDly_q   <= csSync_q;
            mosiMeta_q <= i_mosi; mosiSync_q <= mosiMeta_q;
        end
    end

    // After reset, only accept a new transaction once CS has been seen high,
    // so a transaction cut by reset is ignored until CS is released.
    always_ff @(posedge clk) begin
        if (rst) begin
            settle_q <= 2'd0;
            armed_q  <= 1'b0;
        end else begin
            if (settle_q != 2'd2) settle_q <= settle_q + 2'd1;
            if ((settle_q == 2'd2) && csSync_q) armed_q <= 1'b1;
        end
    end

    // Transaction state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state decode: CS release always wins, opcodes pick read/write.
    always_comb begin
        state_d = state_q;
        if (csRise) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (csFall && armed_q) state_d = CMD;
                CMD:  if (byteDone) state_d = ((rxByte == 8'h0A) || (rxByte == 8'h0B)) ? ADDR : IGNORE;
                ADDR: if (byteDone) state_d = DATA;
                default: state_d = state_q;
            endcase
        end
    end

    // Bit shifting, address tracking and the registered MISO pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            rxCnt_q   <= 3'd0;
            rxShift_q <= 8'h00;
            isRead_q  <= 1'b0;
            addr_q    <= 6'h00;
            txCnt_q   <= 3'd0;
            txShift_q <= 7'h00;
            misoBit_q <= 1'b0;
            miso_q    <= 1'b0;
        end else begin
            if (state_q == IDLE) begin
                rxCnt_q   <= 3'd0;
                txCnt_q   <= 3'd0;
                misoBit_q <= 1'b0;
            end
            if (sclkRise && ((state_q == CMD) || (state_q == ADDR) || (state_q == DATA))) begin
                rxShift_q <= rxByte;
                rxCnt_q   <= rxCnt_q + 3'd1;
            end
            if ((state_q == CMD) && byteDone) isRead_q <= (rxByte == 8'h0B);
            if ((state_q == ADDR) && byteDone) addr_q <= rxByte[5:0];
            if (commitWrite) addr_q <= addr_q + 6'd1;
            if ((state_q == DATA) && isRead_q && sclkFall) begin
                txCnt_q <= txCnt_q + 3'd1;
                if (txLoad) begin
                    misoBit_q <= rdData[7];
                    txShift_q <= rdData[6:0];
                    addr_q    <= addr_q + 6'd1;
                end else begin
                    misoBit_q <= txShift_q[6];
                    txShift_q <= {txShift_q[5:0], 1'b0};
                end
            end
            miso_q <= ((state_q == DATA) && isRead_q) ? misoBit_q : 1'b0;
        end
    end

    // Read/write storage at 0x20-0x3F, cleared by reset or soft reset.
    always_ff @(posedge clk) begin
        if (rst || softReset) begin
            for (int i = 0; i < 32; i++) store_q[i] <= 8'h00;
        end else if (commitWrite && addr_q[5]) begin
            store_q[addr_q[4:0]] <= rxByte;
        end
    end

    // Sample registers, deferred sample buffer and DATA_READY handling.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q <= 12'h000; y_q <= 12'h000; z_q <= 12'h000;
            penX_q <= 12'h000; penY_q <= 12'h000; penZ_q <= 12'h000;
            pending_q    <= 1'b0;
            dataReady_q  <= 1'b0;
            readSample_q <= 1'b0;
        end else begin
            if (txLoad && rdSample) readSample_q <= 1'b1;
            if (csRise) begin
                pending_q    <= 1'b0;
                readSample_q <= 1'b0;
                if (i_sample_valid) begin
                    x_q <= i_x; y_q <= i_y; z_q <= i_z;
                    dataReady_q <= 1'b1;
                end else if (pending_q) begin
                    x_q <= penX_q; y_q <= penY_q; z_q <= penZ_q;
                    dataReady_q <= 1'b1;
                end else if (readSample_q) begin
                    dataReady_q <= 1'b0;
                end
            end else if (i_sample_valid) begin
                if (o_busy) begin
                    penX_q <= i_x; penY_q <= i_y; penZ_q <= i_z;
                    pending_q <= 1'b1;
                end else begin
                    x_q <= i_x; y_q <= i_y; z_q <= i_z;
                    dataReady_q <= 1'b1;
                end
            end
            if (softReset) begin
                x_q <= 12'h000; y_q <= 12'h000; z_q <= 12'h000;
                dataReady_q <= 1'b0;
            end
        end
    end

    // Register map read mux for the current address.
    always_comb begin
        rdData = 8'h00;
        case (addr_q)
            6'h00: rdData = ID_AD;
            6'h01: rdData = ID_MST;
            6'h02: rdData = PART_ID;
            6'h03: rdData = REV_ID;
            6'h08: rdData = x_q[11:4];
            6'h09: rdData = y_q[11:4];
            6'h0A: rdData = z_q[11:4];
            6'h0B: rdData = {7'b0, dataReady_q};
            6'h0E: rdData = x_q[7:0];
            6'h0F: rdData = {{4{x_q[11]}}, x_q[11:8]};
            6'h10: rdData = y_q[7:0];
            6'h11: rdData = {{4{y_q[11]}}, y_q[11:8]};
            6'h12: rdData = z_q[7:0];
            6'h13: rdData = {{4{z_q[11]}}, z_q[11:8]};
            default: if (addr_q[5]) rdData = store_q[addr_q[4:0]];
        endcase
    end

endmodule

// File: tb/tb_spi_accel_responder.sv
// Directed bench for spi_accel_responder: bit-bangs SPI mode 0 transactions and
// compares each received data byte against a scoreboard queue of expectations.
module tb_spi_accel_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        sclk, csn, mosi;
    logic        miso, busy;
    logic        sampleValid;
    logic [11:0] sampleX, sampleY, sampleZ;

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  expQ [$];
    logic [7:0]  txQ  [$];

    spi_accel_responder dut (
        .clk            (clk),
        .rst            (rst),
        .i_sclk         (sclk),
        .i_cs_n         (csn),
        .i_mosi         (mosi),
        .o_miso         (miso),
        .i_sample_valid (sampleValid),
        .i_x            (sampleX),
        .i_y            (sampleY),
        .i_z            (sampleZ),
        .o_busy         (busy)
    );

    // Core clock, 10 ns period.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    // Shift nb bits MSB first; MISO is sampled just before each rising edge.
    task automatic spiBits(input logic [7:0] tx, input int nb, output logic [7:0] rx);
        rx = 8'h00;
        for (int b = 0; b < nb; b++) begin
            mosi = tx[7-b];
            repeat (8) @(negedge clk);
            rx = {rx[6:0], miso};
            sclk = 1'b1;
            repeat (8) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    task automatic csLow();
        @(negedge clk);
        csn = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic csHigh();
        repeat (8) @(negedge clk);
        csn = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    // One full transaction; data bytes come from txQ, expectations from expQ.
    task automatic applyStimulus(input string tag, input logic [7:0] op, input logic [7:0] addr, input int n);
        logic [7:0] rx, tx, exp;
        csLow();
        spiBits(op, 8, rx);
        checkOutput({tag, "-cmd"}, rx, 8'h00);
        spiBits(addr, 8, rx);
        checkOutput({tag, "-addr"}, rx, 8'h00);
        for (int i = 0; i < n; i++) begin
            tx = (txQ.size() > 0) ? txQ.pop_front() : 8'h00;
            spiBits(tx, 8, rx);
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL %s-d%0d scoreboard empty, observed=%02h", tag, i, rx);
            end else begin
                exp = expQ.pop_front();
                checkOutput($sformatf("%s-d%0d", tag, i), rx, exp);
            end
        end
        csHigh();
    endtask

    task automatic pulseSample(input logic [11:0] xv, input logic [11:0] yv, input logic [11:0] zv);
        sampleX = xv; sampleY = yv; sampleZ = zv;
        sampleValid = 1'b1;
        @(negedge clk);
        sampleValid = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        logic [7:0] rx;
        rst = 1'b1; sclk = 1'b0; csn = 1'b1; mosi = 1'b0;
        sampleValid = 1'b0; sampleX = '0; sampleY = '0; sampleZ = '0;
        repeat (4) @(negedge clk);
        checkOutput("rstMiso", {7'b0, miso}, 8'h00);
        checkOutput("rstBusy", {7'b0, busy}, 8'h00);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // ID registers
        expQ.push_back(8'hAD); expQ.push_back(8'h1D); expQ.push_back(8'hF2); expQ.push_back(8'h01);
        applyStimulus("idRead", 8'h0B, 8'h00, 4);

        // Write 0x3E/0x3F, read back with wrap to 0x00
        txQ.push_back(8'h5A); txQ.push_back(8'hC3);
        expQ.push_back(8'h00); expQ.push_back(8'h00);
        applyStimulus("wr3E", 8'h0A, 8'h3E, 2);
        expQ.push_back(8'h5A); expQ.push_back(8'hC3); expQ.push_back(8'hAD);
        applyStimulus("rd3E", 8'h0B, 8'h3E, 3);

        // Sample format and DATA_READY
        expQ.push_back(8'h00);
        applyStimulus("status0", 8'h0B, 8'h0B, 1);
        pulseSample(12'h9AB, 12'h123, 12'hFFF);
        expQ.push_back(8'h01);
        applyStimulus("status1", 8'h0B, 8'h0B, 1);
        expQ.push_back(8'hAB); expQ.push_back(8'hF9); expQ.push_back(8'h23);
        expQ.push_back(8'h01); expQ.push_back(8'hFF); expQ.push_back(8'hFF);
        applyStimulus("burst", 8'h0B, 8'h0E, 6);
        expQ.push_back(8'h00);
        applyStimulus("status2", 8'h0B, 8'h0B, 1);
        expQ.push_back(8'h9A); expQ.push_back(8'h12); expQ.push_back(8'hFF);
        applyStimulus("hiData", 8'h0B, 8'h08, 3);

        // Deferred sample during a burst
        expQ.push_back(8'hAB); expQ.push_back(8'hF9);
        fork
            applyStimulus("deferred", 8'h0B, 8'h0E, 2);
            begin
                repeat (8 + 16*16 + 3*16) @(negedge clk);
                checkOutput("busyMid", {7'b0, busy}, 8'h01);
                sampleX = 12'h001; sampleValid = 1'b1;
                @(negedge clk);
                sampleValid = 1'b0;
            end
        join
        expQ.push_back(8'h01);
        applyStimulus("status3", 8'h0B, 8'h0B, 1);
        expQ.push_back(8'h01); expQ.push_back(8'h00);
        applyStimulus("newX", 8'h0B, 8'h0E, 2);
        expQ.push_back(8'h00);
        applyStimulus("newXhi", 8'h0B, 8'h08, 1);

        // Illegal opcode must not change storage
        txQ.push_back(8'h11); expQ.push_back(8'h00);
        applyStimulus("wr20", 8'h0A, 8'h20, 1);
        txQ.push_back(8'h77); txQ.push_back(8'h77);
        expQ.push_back(8'h00); expQ.push_back(8'h00);
        applyStimulus("illegal", 8'h0D, 8'h20, 2);

        // Aborted write after 20 bits
        csLow();
        spiBits(8'h0A, 8, rx);
        spiBits(8'h21, 8, rx);
        spiBits(8'hEE, 4, rx);
        csHigh();
        expQ.push_back(8'h11); expQ.push_back(8'h00);
        applyStimulus("rd20", 8'h0B, 8'h20, 2);

        // Soft reset
        pulseSample(12'h9AB, 12'h123, 12'hFFF);
        txQ.push_back(8'h52); expQ.push_back(8'h00);
        applyStimulus("soft", 8'h0A, 8'h1F, 1);
        expQ.push_back(8'h00); expQ.push_back(8'h00);
        applyStimulus("rd1F", 8'h0B, 8'h1F, 2);
        expQ.push_back(8'h00); expQ.push_back(8'h00); expQ.push_back(8'hAD);
        applyStimulus("rd3Eclr", 8'h0B, 8'h3E, 3);
        expQ.push_back(8'h00); expQ.push_back(8'h00);
        applyStimulus("sampClr", 8'h0B, 8'h0E, 2);
        expQ.push_back(8'h00);
        applyStimulus("status4", 8'h0B, 8'h0B, 1);

        // Reset in the middle of a read of 0xAD
        csLow();
        spiBits(8'h0B, 8, rx);
        spiBits(8'h00, 8, rx);
        spiBits(8'h00, 2, rx);
        checkOutput("preRstBits", rx, 8'h02);
        repeat (6) @(negedge clk);
        checkOutput("preRstMiso", {7'b0, miso}, 8'h01);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rstMidMiso", {7'b0, miso}, 8'h00);
        rst = 1'b0;
        spiBits(8'hFF, 6, rx);
        checkOutput("postRstBits", rx, 8'h00);
        spiBits(8'hFF, 8, rx);
        checkOutput("postRstByte", rx, 8'h00);
        csHigh();
        expQ.push_back(8'hAD); expQ.push_back(8'h1D);
        applyStimulus("idAfterRst", 8'h0B, 8'h00, 2);

        checkOutput("sbEmpty", 8'(expQ.size()), 8'h00);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
